// File: rtl/himp_bus_rx_pkg.sv
// Shared definitions for the single-wire bus: frame FSM states and default frame geometry.
// The future driver-side serializer imports this package as well.
package himp_bus_rx_pkg;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

endpackage

// File: rtl/himp_bus_rx_sync2.sv
// Two-flop synchroniser with a selectable reset value.
// On the bus receiver it resets to 1 so an idle, pulled-up line is never seen as a start bit.
module himp_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/himp_bus_rx.sv
// Single-wire bus receiver: start(0) + DATA_W data bits (LSB first) + stop(1).
// Each good word is presented on DOUT with a one-cycle DVALID strobe; a bad stop bit gives FERR.
module himp_bus_rx
  import himp_bus_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              BUS_IN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DVALID,
  output logic              FERR,
  output logic              BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  logic bus_s;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                ferr_q, ferr_d;

  himp_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RSTN),
    .d     (BUS_IN),
    .q     (bus_s)
  );

  // START samples at mid-bit; from then on every full period lands mid-bit again.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!bus_s) state_d = ST_START;
      end
      ST_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = bus_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = bus_s;
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bus_s) begin
            dout_d   = shift_q;
            dvalid_d = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (bus_s) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;
  assign FERR   = ferr_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule
